imem_fetch_port: RTL
====================

Name: imem_fetch_port

Overview:
- Parametrised instruction memory with a registered, handshaked fetch port and a streaming program-load port.
- Sits between the PC/fetch stage and decode; replaces the fixed 10-word combinational instruction store.
- Adds run/load modes, fetch back-pressure, address fault detection and NOP substitution on fault.

Parameters:
- XLEN, 32, width of PC and instruction word
- DEPTH, 64, number of instruction words; power of two, >= 2
- AW, $clog2(DEPTH), word-index width
- NOP_WORD, 32'h00000013, instruction returned on fault and after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted this cycle when high with req_valid
- req_pc  in  XLEN  byte address of the instruction
- rsp_valid  out  1  fetch response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_instr  out  XLEN  fetched instruction, or NOP_WORD on fault
- rsp_pc  out  XLEN  PC of the response
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range
- prog_start  in  1  enter LOAD mode and reset the write pointer to 0
- prog_valid  in  1  prog_data valid
- prog_data  in  XLEN  word to store at the write pointer
- prog_done  in  1  leave LOAD mode
- prog_count  out  AW+1  words written in the current or last load
- prog_err  out  1  sticky overflow flag for the current or last load
- busy_load  out  1  high while in LOAD

Behaviour:
- Reset (sync, active-high), applied on the next clk edge:
  - state=RUN, rsp_valid=0, rsp_instr=NOP_WORD, rsp_pc=0, rsp_fault=00.
  - prog_count=0, prog_err=0, busy_load=0.
  - Memory contents are not cleared; reset mid-load abandons LOAD with already-written words retained.
- FSM states RUN and LOAD:
  - RUN -> LOAD when prog_start=1; same edge sets pointer=0, prog_count=0, prog_err=0.
  - LOAD -> RUN when prog_done=1. A prog_valid in that same cycle is still written.
  - prog_start in LOAD restarts the load (pointer and count to 0, err cleared).
  - busy_load = (state==LOAD).
- LOAD writes:
  - Each cycle with prog_valid=1 and pointer < DEPTH: mem[pointer]=prog_data, pointer++, prog_count++.
  - prog_valid with pointer == DEPTH: no write, prog_err=1 (sticky until next prog_start or rst), count holds at DEPTH.
- Fetch handshake (RUN only):
  - req_ready = (state==RUN) && (!rsp_valid || rsp_ready). It is combinational and 0 throughout LOAD.
  - A request is accepted on the edge where req_valid && req_ready.
  - The response is registered and appears on the next cycle (latency 1): rsp_valid=1, rsp_pc=req_pc.
  - When rsp_valid && !rsp_ready, rsp_* hold stable and no new request is accepted.
  - Accept and drain in the same cycle gives back-to-back throughput of 1 fetch per cycle.
  - If the response drains with no new accept, rsp_valid falls to 0; rsp_instr, rsp_pc and rsp_fault hold their last values.
- Fault rules:
  - req_pc[1:0] != 0: fault 01, instr NOP_WORD.
  - Otherwise (req_pc>>2) >= DEPTH: fault 10, instr NOP_WORD.
  - Misaligned takes priority over out-of-range.
  - The full XLEN PC is compared, so no wrap-around aliasing.
- Transition to LOAD while a response is pending:
  - The pending response is kept until rsp_ready drains it.
  - Memory writes in LOAD do not alter an already registered rsp_instr.
- Read/write collision cannot occur, because fetch is disabled in LOAD.

Test Plan:
- Reset then idle:
  - rsp_valid=0, rsp_instr=32'h00000013, req_ready=1, prog_count=0.
- Load and fetch:
  - prog_start, then 3 prog_valid words 32'h00500093, 32'h00A00113, 32'h002081B3, then prog_done.
  - Expect prog_count=3, prog_err=0.
  - Fetch PCs 0, 4, 8 back-to-back with rsp_ready=1: responses on consecutive cycles with those words and fault 00.
- Back-pressure:
  - Fetch PC 4, hold rsp_ready=0 for 3 cycles while req_valid stays high with PC 8.
  - req_ready=0 and rsp_instr=32'h00A00113 held stable.
  - Release rsp_ready: PC 8 is accepted the same cycle and its response appears next cycle.
- Faults:
  - PC 32'h6 -> fault 01, NOP.
  - PC 4*DEPTH -> fault 10, NOP.
  - PC 32'hFFFFFFFE -> fault 01 (misaligned takes priority).
- Overflow:
  - DEPTH=4, load 5 words -> prog_count=4, prog_err=1.
  - mem[3] keeps the 4th word; the 5th word is discarded.
- Mid-operation events:
  - prog_start during a stalled response: busy_load=1, req_ready=0, and the response still drains on rsp_ready.
  - rst asserted during LOAD -> RUN next cycle, and words already written are fetchable.

Source files
------------

// File: rtl/imem_fetch_port.sv
// ---------------------------------------------------------------------------
// imem_fetch_port
//   Parametrised instruction memory. It sits between the PC/fetch stage and
//   decode, and has two ports:
//     - a registered, valid/ready fetch port (latency 1, one fetch per cycle)
//     - a streaming program-load port that fills memory from word 0 upward
//   The block has two modes. In RUN, fetches are served. In LOAD, the memory
//   is being written and fetch is disabled. A faulting fetch returns NOP_WORD
//   with a fault code.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o fetch request handshake; req_pc_i is a byte address
//   rsp_valid_o/ready_i fetch response handshake
//   rsp_instr_o         fetched word, or NOP_WORD on fault
//   rsp_pc_o            PC that produced the response
//   rsp_fault_o         2'b00 ok, 2'b01 misaligned, 2'b10 out of range
//   prog_start_i        enter (or restart) LOAD, write pointer back to 0
//   prog_valid_i/data_i word to store at the write pointer
//   prog_done_i         leave LOAD
//   prog_count_o        words written in the current or last load
//   prog_err_o          sticky overflow flag for the current or last load
//   busy_load_o         high while in LOAD
// ---------------------------------------------------------------------------
module imem_fetch_port #(
   parameter int                 XLEN     = 32,
   parameter int                 DEPTH    = 64,
   parameter int                 AW       = $clog2(DEPTH),
   parameter logic [XLEN-1:0]    NOP_WORD = 32'h00000013
) (
   input  logic            clk_i,
   input  logic            rst_i,
   // fetch request
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [XLEN-1:0] req_pc_i,
   // fetch response
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_instr_o,
   output logic [XLEN-1:0] rsp_pc_o,
   output logic [1:0]      rsp_fault_o,
   // program load
   input  logic            prog_start_i,
   input  logic            prog_valid_i,
   input  logic [XLEN-1:0] prog_data_i,
   input  logic            prog_done_i,
   output logic [AW:0]     prog_count_o,
   output logic            prog_err_o,
   output logic            busy_load_o
);

   typedef enum logic {S_RUN = 1'b0, S_LOAD = 1'b1} state_e;

   localparam logic [1:0]  FLT_OK  = 2'b00;
   localparam logic [1:0]  FLT_MIS = 2'b01;
   localparam logic [1:0]  FLT_OOR = 2'b10;
   localparam logic [AW:0] FULL_W  = (AW+1)'(DEPTH);

   state_e            state_q, state_d;

   logic [XLEN-1:0]   mem_q [DEPTH];

   // The write pointer and the word count are the same quantity. The pointer
   // stops at DEPTH, which is why it is one bit wider than a word index.
   logic [AW:0]       ptr_q, ptr_d;
   logic              err_q, err_d;
   logic              full;
   logic              wr_en;

   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_instr_q, rsp_instr_d;
   logic [XLEN-1:0]   rsp_pc_q,    rsp_pc_d;
   logic [1:0]        rsp_fault_q, rsp_fault_d;

   logic              accept;
   logic              misaligned;
   logic              out_of_range;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_RUN;
      else       state_q <= state_d;
   end

   // ------------------------------------------------------------------------
   // FSM: next state. If prog_start and prog_done arrive together in LOAD,
   // prog_start wins and the load restarts.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RUN:  if (prog_start_i) state_d = S_LOAD;
         S_LOAD: begin
            if      (prog_start_i) state_d = S_LOAD;
            else if (prog_done_i)  state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs. req_ready does not wait on req_valid, so an upstream stage
   // can use it directly to decide whether to advance.
   // ------------------------------------------------------------------------
   always_comb begin
      busy_load_o = (state_q == S_LOAD);
      req_ready_o = (state_q == S_RUN) && (!rsp_valid_q || rsp_ready_i);
   end

   // ------------------------------------------------------------------------
   // Program load. A restart in the same cycle as prog_valid drops the word,
   // because the pointer is rewound on that edge.
   // ------------------------------------------------------------------------
   assign full  = (ptr_q == FULL_W);
   assign wr_en = !rst_i && (state_q == S_LOAD) && prog_valid_i &&
                  !prog_start_i && !full;

   always_comb begin
      ptr_d = ptr_q;
      err_d = err_q;
      if (prog_start_i) begin
         ptr_d = '0;
         err_d = 1'b0;
      end else if (state_q == S_LOAD && prog_valid_i) begin
         if (full) err_d = 1'b1;
         else      ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
         err_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         err_q <= err_d;
      end
   end

   // Storage is not reset. A reset in the middle of a load keeps the words
   // that were already written.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[ptr_q[AW-1:0]] <= prog_data_i;
   end

   assign prog_count_o = ptr_q;
   assign prog_err_o   = err_q;

   // ------------------------------------------------------------------------
   // Fetch. Out-of-range is decided on every PC bit above the word index, so
   // high addresses never alias back into the array.
   // ------------------------------------------------------------------------
   assign accept       = req_valid_i && req_ready_o;
   assign misaligned   = |req_pc_i[1:0];
   assign out_of_range = |req_pc_i[XLEN-1:AW+2];

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_instr_d = rsp_instr_q;
      rsp_pc_d    = rsp_pc_q;
      rsp_fault_d = rsp_fault_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_pc_d    = req_pc_i;
         if (misaligned) begin
            rsp_instr_d = NOP_WORD;
            rsp_fault_d = FLT_MIS;
         end else if (out_of_range) begin
            rsp_instr_d = NOP_WORD;
            rsp_fault_d = FLT_OOR;
         end else begin
            rsp_instr_d = mem_q[req_pc_i[AW+1:2]];
            rsp_fault_d = FLT_OK;
         end
      end else if (rsp_ready_i) begin
         // Drained with nothing new: drop valid, keep the data fields.
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= NOP_WORD;
         rsp_pc_q    <= '0;
         rsp_fault_q <= FLT_OK;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_instr_q <= rsp_instr_d;
         rsp_pc_q    <= rsp_pc_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_instr_o = rsp_instr_q;
   assign rsp_pc_o    = rsp_pc_q;
   assign rsp_fault_o = rsp_fault_q;

endmodule
